// File: rtl/csr_file.sv
// Machine-mode CSR storage with a 64-bit cycle counter, two combinational read
// ports (decode and clint) and a write port from ex that takes priority over clint.
module csr_file (
  input  logic        CycleCntEn,
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        clint_we_i,
  input  logic [31:0] clint_raddr_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_wdata_i,
  output logic [31:0] clint_rdata_o,
  output logic        global_int_en_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  logic [31:0] mstatus_r;
  logic [31:0] mie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [63:0] cnt_r;

  logic        wr_en_s;
  logic [11:0] wr_addr_s;
  logic [31:0] wr_data_s;
  logic [63:0] cnt_next_s;
  logic [63:0] cnt_upd_s;
  logic [31:0] rdata_s;
  logic [31:0] clint_rdata_s;
  logic        unused_addr_bits_s;

  assign unused_addr_bits_s = ^{raddr_i[31:12], waddr_i[31:12],
                                clint_raddr_i[31:12], clint_waddr_i[31:12]};

  function automatic logic is_writable(input logic [11:0] addr);
    case (addr)
      ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
      ADDR_MEPC, ADDR_MCAUSE, ADDR_MCYCLE, ADDR_MCYCLEH: is_writable = 1'b1;
      default:                                           is_writable = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_read(
    input logic [11:0] addr,
    input logic [31:0] mstatus,
    input logic [31:0] mie,
    input logic [31:0] mtvec,
    input logic [31:0] mscratch,
    input logic [31:0] mepc,
    input logic [31:0] mcause,
    input logic [63:0] cnt
  );
    case (addr)
      ADDR_MSTATUS:              csr_read = mstatus;
      ADDR_MIE:                  csr_read = mie;
      ADDR_MTVEC:                csr_read = mtvec;
      ADDR_MSCRATCH:             csr_read = mscratch;
      ADDR_MEPC:                 csr_read = mepc;
      ADDR_MCAUSE:               csr_read = mcause;
      ADDR_MCYCLE, ADDR_CYCLE:   csr_read = cnt[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH: csr_read = cnt[63:32];
      ADDR_MHARTID:              csr_read = 32'h0000_0000;
      default:                   csr_read = 32'h0000_0000;
    endcase
  endfunction

  // Write arbitration: ex wins, clint only when ex is idle.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 12'h000;
    wr_data_s = 32'h0000_0000;
    if (we_i) begin
      wr_en_s   = 1'b1;
      wr_addr_s = waddr_i[11:0];
      wr_data_s = wdata_i;
    end else if (clint_we_i) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clint_waddr_i[11:0];
      wr_data_s = clint_wdata_i;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Counter next value: increment first, then a write replaces one half of it.
  always_comb begin
    cnt_next_s = CycleCntEn ? (cnt_r + 64'd1) : cnt_r;
    cnt_upd_s  = cnt_next_s;
    if (wr_en_s && (wr_addr_s == ADDR_MCYCLE)) begin
      cnt_upd_s[31:0] = wr_data_s;
    end else if (wr_en_s && (wr_addr_s == ADDR_MCYCLEH)) begin
      cnt_upd_s[63:32] = wr_data_s;
    end else begin
      cnt_upd_s = cnt_next_s;
    end
  end

  // Decode read port, bypassing in-flight ex writes to writable addresses.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (!rst_n) begin
      rdata_s = 32'h0000_0000;
    end else if (we_i && (waddr_i[11:0] == raddr_i[11:0]) && is_writable(raddr_i[11:0])) begin
      rdata_s = wdata_i;
    end else begin
      rdata_s = csr_read(raddr_i[11:0], mstatus_r, mie_r, mtvec_r, mscratch_r,
                         mepc_r, mcause_r, cnt_r);
    end
  end

  // Clint read port; only the ex write port is bypassed.
  always_comb begin
    clint_rdata_s = 32'h0000_0000;
    if (!rst_n) begin
      clint_rdata_s = 32'h0000_0000;
    end else if (we_i && (waddr_i[11:0] == clint_raddr_i[11:0]) &&
                 is_writable(clint_raddr_i[11:0])) begin
      clint_rdata_s = wdata_i;
    end else begin
      clint_rdata_s = csr_read(clint_raddr_i[11:0], mstatus_r, mie_r, mtvec_r,
                               mscratch_r, mepc_r, mcause_r, cnt_r);
    end
  end

  assign rdata_o       = rdata_s;
  assign clint_rdata_o = clint_rdata_s;

  // CSR state and counter update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_r  <= 32'h0000_0000;
      mie_r      <= 32'h0000_0000;
      mtvec_r    <= 32'h0000_0000;
      mscratch_r <= 32'h0000_0000;
      mepc_r     <= 32'h0000_0000;
      mcause_r   <= 32'h0000_0000;
      cnt_r      <= 64'd0;
    end else begin
      cnt_r <= cnt_upd_s;
      if (wr_en_s) begin
        case (wr_addr_s)
          ADDR_MSTATUS:  mstatus_r  <= wr_data_s;
          ADDR_MIE:      mie_r      <= wr_data_s;
          ADDR_MTVEC:    mtvec_r    <= wr_data_s;
          ADDR_MSCRATCH: mscratch_r <= wr_data_s;
          ADDR_MEPC:     mepc_r     <= wr_data_s;
          ADDR_MCAUSE:   mcause_r   <= wr_data_s;
          default:       mstatus_r  <= mstatus_r;
        endcase
      end else begin
        mstatus_r <= mstatus_r;
      end
    end
  end

  assign global_int_en_o = mstatus_r[3];
  assign mtvec_o         = mtvec_r;
  assign mepc_o          = mepc_r;
  assign mstatus_o       = mstatus_r;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: one task per scenario, inline checks.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CycleCntEn;
  logic [31:0] raddr_i;
  logic [31:0] rdata_o;
  logic        we_i;
  logic [31:0] waddr_i;
  logic [31:0] wdata_i;
  logic        clint_we_i;
  logic [31:0] clint_raddr_i;
  logic [31:0] clint_waddr_i;
  logic [31:0] clint_wdata_i;
  logic [31:0] clint_rdata_o;
  logic        global_int_en_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic [31:0] mstatus_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  csr_file dut (
    .CycleCntEn(CycleCntEn), .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .clint_we_i(clint_we_i), .clint_raddr_i(clint_raddr_i),
    .clint_waddr_i(clint_waddr_i), .clint_wdata_i(clint_wdata_i),
    .clint_rdata_o(clint_rdata_o), .global_int_en_o(global_int_en_o),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    we_i = 1'b0; clint_we_i = 1'b0;
    waddr_i = 32'h0; wdata_i = 32'h0;
    clint_waddr_i = 32'h0; clint_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; CycleCntEn = 1'b1;
    idle_ports();
    raddr_i = 32'h300; clint_raddr_i = 32'h305;
    tick(); tick();
    we_i = 1'b1; waddr_i = 32'h300; wdata_i = 32'h5;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h0) $display("FAIL reset_rdata_bypass: got %h want %h", rdata_o, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if ({mtvec_o, mepc_o, mstatus_o, global_int_en_o} !== 97'h0)
      $display("FAIL reset_exports: got %h %h %h %b want 0", mtvec_o, mepc_o, mstatus_o, global_int_en_o);
    else pass_cnt++;
    tick();
    idle_ports();
    rst_n = 1'b1;
    raddr_i = 32'h300; clint_raddr_i = 32'h305;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== 64'h0) $display("FAIL reset_mstatus_mtvec: got %h %h want 0 0", rdata_o, clint_rdata_o);
    else pass_cnt++;
    raddr_i = 32'hB00;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h0) $display("FAIL reset_mcycle_pre: got %h want %h", rdata_o, 32'h0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rdata_o !== 32'h1) $display("FAIL reset_mcycle_first_edge: got %h want %h", rdata_o, 32'h1);
    else pass_cnt++;
    total_cnt++;
    if (global_int_en_o !== 1'b0) $display("FAIL reset_gie: got %b want 0", global_int_en_o);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    we_i = 1'b1; waddr_i = 32'h305; wdata_i = 32'h8000_0100;
    raddr_i = 32'h305; clint_raddr_i = 32'h305;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h8000_0100) $display("FAIL bypass_rdata: got %h want %h", rdata_o, 32'h8000_0100);
    else pass_cnt++;
    total_cnt++;
    if (clint_rdata_o !== 32'h8000_0100) $display("FAIL bypass_clint_rdata: got %h want %h", clint_rdata_o, 32'h8000_0100);
    else pass_cnt++;
    total_cnt++;
    if (mtvec_o !== 32'h0) $display("FAIL bypass_export_early: got %h want %h", mtvec_o, 32'h0);
    else pass_cnt++;
    tick();
    idle_ports();
    #1;
    total_cnt++;
    if (mtvec_o !== 32'h8000_0100) $display("FAIL bypass_mtvec_export: got %h want %h", mtvec_o, 32'h8000_0100);
    else pass_cnt++;
    // clint writes are never bypassed
    clint_we_i = 1'b1; clint_waddr_i = 32'h342; clint_wdata_i = 32'h77;
    raddr_i = 32'h342; clint_raddr_i = 32'h342;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== 64'h0) $display("FAIL no_clint_bypass: got %h %h want 0 0", rdata_o, clint_rdata_o);
    else pass_cnt++;
    tick();
    idle_ports();
    #1;
    total_cnt++;
    if (rdata_o !== 32'h77) $display("FAIL clint_write_mcause: got %h want %h", rdata_o, 32'h77);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    we_i = 1'b1; waddr_i = 32'h341; wdata_i = 32'h11;
    clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_wdata_i = 32'h22;
    tick();
    idle_ports();
    clint_raddr_i = 32'h341;
    #1;
    total_cnt++;
    if (mepc_o !== 32'h11) $display("FAIL collision_mepc: got %h want %h", mepc_o, 32'h11);
    else pass_cnt++;
    total_cnt++;
    if (clint_rdata_o !== 32'h11) $display("FAIL collision_clint_rdata: got %h want %h", clint_rdata_o, 32'h11);
    else pass_cnt++;
    we_i = 1'b1; waddr_i = 32'h340; wdata_i = 32'hA;
    clint_we_i = 1'b1; clint_waddr_i = 32'h342; clint_wdata_i = 32'hB;
    tick();
    idle_ports();
    raddr_i = 32'h340; clint_raddr_i = 32'h342;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== {32'hA, 32'h77})
      $display("FAIL collision_diff_addr: got %h %h want %h %h", rdata_o, clint_rdata_o, 32'hA, 32'h77);
    else pass_cnt++;
  endtask

  task automatic test_int_en();
    clint_we_i = 1'b1; clint_waddr_i = 32'h300; clint_wdata_i = 32'h8;
    tick();
    idle_ports();
    #1;
    total_cnt++;
    if ({global_int_en_o, mstatus_o} !== {1'b1, 32'h8})
      $display("FAIL int_en_set: got %b %h want 1 %h", global_int_en_o, mstatus_o, 32'h8);
    else pass_cnt++;
    we_i = 1'b1; waddr_i = 32'h300; wdata_i = 32'h0;
    #1;
    total_cnt++;
    if (global_int_en_o !== 1'b1) $display("FAIL int_en_no_export_bypass: got %b want 1", global_int_en_o);
    else pass_cnt++;
    tick();
    idle_ports();
    #1;
    total_cnt++;
    if (global_int_en_o !== 1'b0) $display("FAIL int_en_clear: got %b want 0", global_int_en_o);
    else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    we_i = 1'b1; waddr_i = 32'hB80; wdata_i = 32'hFFFF_FFFF;
    tick();
    waddr_i = 32'hB00; wdata_i = 32'hFFFF_FFFF;
    tick();
    idle_ports();
    raddr_i = 32'hB00; clint_raddr_i = 32'hB80;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL wrap_all_ones: got %h %h want ffffffff ffffffff", rdata_o, clint_rdata_o);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== {32'h1, 32'h0})
      $display("FAIL wrap_mcycle: got %h %h want 1 0", rdata_o, clint_rdata_o);
    else pass_cnt++;
    raddr_i = 32'hC00; clint_raddr_i = 32'hC80;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== {32'h1, 32'h0})
      $display("FAIL wrap_cycle_alias: got %h %h want 1 0", rdata_o, clint_rdata_o);
    else pass_cnt++;
    we_i = 1'b1; waddr_i = 32'hB00; wdata_i = 32'hFFFF_FFFF;
    tick();
    idle_ports();
    raddr_i = 32'hB00; clint_raddr_i = 32'hB80;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== {32'hFFFF_FFFF, 32'h0})
      $display("FAIL carry_pre: got %h %h want ffffffff 0", rdata_o, clint_rdata_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== {32'h0, 32'h1})
      $display("FAIL carry_post: got %h %h want 0 1", rdata_o, clint_rdata_o);
    else pass_cnt++;
    CycleCntEn = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== {32'h0, 32'h1})
      $display("FAIL cnt_hold: got %h %h want 0 1", rdata_o, clint_rdata_o);
    else pass_cnt++;
    we_i = 1'b1; waddr_i = 32'hB00; wdata_i = 32'h7;
    tick();
    idle_ports();
    #1;
    total_cnt++;
    if (rdata_o !== 32'h7) $display("FAIL cnt_hold_write: got %h want %h", rdata_o, 32'h7);
    else pass_cnt++;
    CycleCntEn = 1'b1;
  endtask

  task automatic test_illegal();
    we_i = 1'b1; waddr_i = 32'hB80; wdata_i = 32'h0;
    tick();
    waddr_i = 32'hB00; wdata_i = 32'h100;
    tick();
    waddr_i = 32'hC00; wdata_i = 32'h1234;
    raddr_i = 32'hC00;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h100) $display("FAIL ro_no_bypass: got %h want %h", rdata_o, 32'h100);
    else pass_cnt++;
    tick();
    waddr_i = 32'hF14; wdata_i = 32'h5;
    raddr_i = 32'hB00;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h101) $display("FAIL ro_cycle_write: got %h want %h", rdata_o, 32'h101);
    else pass_cnt++;
    tick();
    waddr_i = 32'h7C0; wdata_i = 32'hAA;
    raddr_i = 32'hF14;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h0) $display("FAIL mhartid_read: got %h want %h", rdata_o, 32'h0);
    else pass_cnt++;
    tick();
    waddr_i = 32'hC80; wdata_i = 32'h9;
    tick();
    idle_ports();
    raddr_i = 32'h7C0; clint_raddr_i = 32'hB00;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== {32'h0, 32'h104})
      $display("FAIL unmapped_and_cnt: got %h %h want 0 %h", rdata_o, clint_rdata_o, 32'h104);
    else pass_cnt++;
    raddr_i = 32'hB80; clint_raddr_i = 32'h304;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== 64'h0) $display("FAIL illegal_hi_mie: got %h %h want 0 0", rdata_o, clint_rdata_o);
    else pass_cnt++;
    total_cnt++;
    if ({mtvec_o, mepc_o, mstatus_o} !== {32'h8000_0100, 32'h11, 32'h0})
      $display("FAIL illegal_exports: got %h %h %h want 80000100 11 0", mtvec_o, mepc_o, mstatus_o);
    else pass_cnt++;
    raddr_i = 32'hFFFF_F305;
    #1;
    total_cnt++;
    if (rdata_o !== 32'h8000_0100) $display("FAIL upper_addr_ignored: got %h want %h", rdata_o, 32'h8000_0100);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    we_i = 1'b1; waddr_i = 32'h340; wdata_i = 32'h55;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mtvec_o, mepc_o} !== 64'h0) $display("FAIL mid_reset_async: got %h %h want 0 0", mtvec_o, mepc_o);
    else pass_cnt++;
    tick();
    idle_ports();
    rst_n = 1'b1;
    raddr_i = 32'h340; clint_raddr_i = 32'hB00;
    #1;
    total_cnt++;
    if ({rdata_o, clint_rdata_o} !== 64'h0) $display("FAIL mid_reset_write_lost: got %h %h want 0 0", rdata_o, clint_rdata_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_int_en();
    test_counter_wrap();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
